bdd_cone_sampler: RTL and testbench
===================================

Name: bdd_cone_sampler

Overview:
- Drives stimulus into a generated single-output logic cone, with flat input vector `i` and output `o`, and reads back the cone's response.
- Enumerates every combination of up to NVAR selected support inputs over a fixed base vector.
- Captures the output bit for each combination and streams the packed truth table out over a valid/ready interface.
- Used to extract and check per-output-bit cone functions against their source truth tables.

Parameters:
- IN_W, 1894, width of the cone input vector.
- NVAR, 8, maximum number of enumerated support variables.
- IDX_W, 11, width of one variable index; must satisfy 2**IDX_W >= IN_W.
- OUT_W, 32, truth-table stream word width; power of two.
- CONE_LAT, 0, extra settle cycles per minterm before cone_o is sampled.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a sweep; ignored while busy=1.
- base_vec  in  IN_W  background value for all non-enumerated inputs; captured on start.
- var_idx  in  NVAR*IDX_W  variable k is at [k*IDX_W +: IDX_W]; captured on start.
- nvar  in  $clog2(NVAR+1)  number of enumerated variables, 0..NVAR; captured on start.
- busy  out  1  sweep in progress.
- cone_i  out  IN_W  registered stimulus to the cone.
- cone_o  in  1  cone response.
- tt_data  out  OUT_W  truth-table word.
- tt_valid  out  1  tt_data valid.
- tt_ready  in  1  consumer accepts.
- tt_last  out  1  final word of the sweep.
- done  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset, asynchronous, from any state:
  - all outputs go to 0 (cone_i=0, tt_data=0);
  - FSM returns to IDLE; the sweep in progress is abandoned and no further words are produced.
- FSM states:
  - IDLE: on start, latch inputs; m=0; go to DRIVE.
  - DRIVE: register cone_i = base_vec with bit var_idx[k] overwritten by bit k of the minterm, for k<nvar; go to SETTLE.
  - SETTLE: wait CONE_LAT cycles (0 means pass straight through); go to SAMPLE.
  - SAMPLE: write cone_o into word bit (m mod OUT_W).
    - If the word is full or m = 2^nvar-1, go to EMIT.
    - Otherwise m++ and go to DRIVE.
  - EMIT: hold tt_valid=1. On tt_ready:
    - if last, go to DONE;
    - else clear the word buffer, m++, go to DRIVE.
  - DONE: pulse done for 1 cycle, drop busy, go to IDLE.
- Sample timing: each minterm is presented on cone_i for CONE_LAT+1 full cycles before cone_o is sampled. cone_o may be combinational from cone_i.
- Word layout: minterm m lands in word m/OUT_W, bit m%OUT_W.
  - A final word that is only partly filled is zero-padded above bit (2^nvar-1)%OUT_W.
  - nvar=0 yields exactly one sample and one word.
- Word count: ceil(2^nvar/OUT_W), minimum 1. tt_last is asserted with the last word only.
- Handshake:
  - tt_data and tt_last stay stable while tt_valid & !tt_ready.
  - tt_valid never drops without a handshake except on reset.
  - cone_i holds its value during EMIT.
- Duplicate indices: higher k wins.
- Index >= IN_W: that variable drives no input bit, but it is still counted in 2^nvar.
- nvar > NVAR: clamped to NVAR.
- busy: high from the cycle after start through the done cycle. start arriving in the same cycle as done is ignored.
- Inputs that change mid-sweep have no effect.

Optional Feature:
SAMPLER_GRAY_EN
- Defined:
  - the enumeration order is Gray code g(n) = n ^ (n>>1), for n = 0..2^nvar-1;
  - cone_i then changes by exactly one bit between consecutive minterms;
  - each response is stored at bit position g(n), so tt_data contents are identical to natural order.
  - Because bits are then filled out of order, every word is emitted only after all its positions have been filled. Gray order fills every aligned OUT_W block contiguously.
- Undefined: natural binary order (m increments by 1).

Decomposition:
- Package bdd_sampler_pkg:
  - FSM state enum (IDLE, DRIVE, SETTLE, SAMPLE, EMIT, DONE);
  - default IN_W/NVAR/IDX_W/OUT_W localparams;
  - function to_gray.
- Sub-module bdd_minterm_seq:
  - step counter, terminal detect, and Gray/natural mapping;
  - outputs the current minterm value and a last flag.
- The top level holds the FSM, stimulus register, word buffer and stream handshake.

Test Plan:
- Parity (7:1 mux tree is similar):
  - Stimulus: cone o = XOR of i[1713..1718]; var_idx = {1718..1713}; nvar=6; base 0; tt_ready=1.
  - Required: words 0x96696996 then 0x69969669; tt_last on the second word; done pulse.
- Two-variable AND with inversion:
  - Stimulus: cone o = i[5] & !i[9]; var_idx = {9,5}; nvar=2.
  - Required: single word 0x00000002 with tt_last=1.
- Zero variables:
  - Stimulus: nvar=0; base_vec[63]=1; cone o = i[63].
  - Required: one word 0x00000001 with tt_last=1. With base_vec[63]=0, the word is 0x00000000.
- Backpressure:
  - Stimulus: parity case with tt_ready held low for 10 cycles on the first word.
  - Required: tt_data stays 0x96696996 and tt_valid stays 1; cone_i does not change; the second word still follows correctly.
- Reset mid-sweep:
  - Stimulus: assert rst during SETTLE of minterm 17 (nvar=6, CONE_LAT=3).
  - Required: all outputs 0 immediately; no further tt_valid. A new start replays the full sweep with correct words.
- Gray order (with SAMPLER_GRAY_EN):
  - Stimulus: nvar=3, cone o = i[var2].
  - Required: the enumerated-bit sequence on cone_i is 0,1,3,2,6,7,5,4 (Hamming distance 1 per step); tt_data = 0x000000F0.

Source files
------------

// File: rtl/bdd_sampler_pkg.sv
// Shared types and defaults for the BDD cone sampler.
// Optional build macro SAMPLER_GRAY_EN selects Gray enumeration order (see bdd_minterm_seq).
package bdd_sampler_pkg;
  localparam int DEF_IN_W  = 1894;
  localparam int DEF_NVAR  = 8;
  localparam int DEF_IDX_W = 11;
  localparam int DEF_OUT_W = 32;

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, EMIT, DONE} state_e;

  function automatic logic [31:0] to_gray(input logic [31:0] n);
    return n ^ (n >> 1);
  endfunction
endpackage

// File: rtl/bdd_minterm_seq.sv
// Minterm step counter with terminal / word-end detection.
// With SAMPLER_GRAY_EN defined the step is mapped through Gray code, else natural order.
module bdd_minterm_seq
  import bdd_sampler_pkg::*;
#(
  parameter int NVAR   = DEF_NVAR,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int NVW    = $clog2(NVAR + 1),
  parameter int LOG_OW = $clog2(OUT_W),
  parameter int CW     = (NVAR > LOG_OW) ? NVAR : LOG_OW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NVW-1:0] nv_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] minterm_o,
  output logic          last_o,
  output logic          word_end_o
);
  logic [CW-1:0] step_q, step_d, term;

  // 1<<NVAR wraps to zero in CW bits, so the subtraction still yields all-ones.
  assign term = (CW'(1) << nv_i) - CW'(1);

  always_comb begin
    step_d = step_q;
    if (clr_i)      step_d = '0;
    else if (inc_i) step_d = step_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) step_q <= '0;
    else     step_q <= step_d;

  assign last_o     = (step_q == term);
  // Gray code keeps each aligned OUT_W block of steps inside the same word.
  assign word_end_o = &step_q[LOG_OW-1:0];

`ifdef SAMPLER_GRAY_EN
  assign minterm_o = CW'(to_gray(32'(step_q)));
`else
  assign minterm_o = step_q;
`endif
endmodule

// File: rtl/bdd_cone_sampler.sv
// Sweeps up to NVAR support inputs of a logic cone and streams the packed truth table.
// Enumeration order follows bdd_minterm_seq (SAMPLER_GRAY_EN selects Gray order).
module bdd_cone_sampler
  import bdd_sampler_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int NVAR     = DEF_NVAR,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int CONE_LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [IN_W-1:0]         base_vec,
  input  logic [NVAR*IDX_W-1:0]   var_idx,
  input  logic [$clog2(NVAR+1)-1:0] nvar,
  output logic                    busy,
  output logic [IN_W-1:0]         cone_i,
  input  logic                    cone_o,
  output logic [OUT_W-1:0]        tt_data,
  output logic                    tt_valid,
  input  logic                    tt_ready,
  output logic                    tt_last,
  output logic                    done
);
  localparam int NVW    = $clog2(NVAR + 1);
  localparam int LOG_OW = $clog2(OUT_W);
  localparam int CW     = (NVAR > LOG_OW) ? NVAR : LOG_OW;
  localparam int LATW   = (CONE_LAT > 1) ? $clog2(CONE_LAT) : 1;

  state_e                  state_q, state_d;
  logic [IN_W-1:0]         base_q, cone_q, stim;
  logic [NVAR*IDX_W-1:0]   idx_q;
  logic [NVW-1:0]          nv_q, nv_clamp;
  logic [OUT_W-1:0]        word_q;
  logic [LATW-1:0]         lat_q;
  logic [CW-1:0]           minterm;
  logic                    seq_last, seq_wend, seq_clr, seq_inc;

  assign nv_clamp = (nvar > NVW'(NVAR)) ? NVW'(NVAR) : nvar;
  assign seq_clr  = (state_q == IDLE);
  assign seq_inc  = ((state_q == SAMPLE) && !(seq_wend || seq_last)) ||
                    ((state_q == EMIT) && tt_ready && !seq_last);

  bdd_minterm_seq #(.NVAR(NVAR), .OUT_W(OUT_W)) u_seq (
    .clk        (clk),
    .rst        (rst),
    .nv_i       (nv_q),
    .clr_i      (seq_clr),
    .inc_i      (seq_inc),
    .minterm_o  (minterm),
    .last_o     (seq_last),
    .word_end_o (seq_wend)
  );

  // Ascending k so a duplicated index resolves to the highest k.
  always_comb begin
    stim = base_q;
    for (int k = 0; k < NVAR; k++)
      if (NVW'(k) < nv_q && int'(idx_q[k*IDX_W +: IDX_W]) < IN_W)
        stim[idx_q[k*IDX_W +: IDX_W]] = minterm[k];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   state_d = (CONE_LAT == 0) ? SAMPLE : SETTLE;
      SETTLE:  if (lat_q == LATW'(CONE_LAT - 1)) state_d = SAMPLE;
      SAMPLE:  state_d = (seq_wend || seq_last) ? EMIT : DRIVE;
      EMIT:    if (tt_ready) state_d = seq_last ? DONE : DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    tt_valid = (state_q == EMIT);
    tt_last  = (state_q == EMIT) && seq_last;
    done     = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      base_q <= '0;
      idx_q  <= '0;
      nv_q   <= '0;
      cone_q <= '0;
      word_q <= '0;
      lat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          base_q <= base_vec;
          idx_q  <= var_idx;
          nv_q   <= nv_clamp;
          word_q <= '0;
        end
        DRIVE: begin
          cone_q <= stim;
          lat_q  <= '0;
        end
        SETTLE: lat_q <= lat_q + LATW'(1);
        SAMPLE: word_q[minterm[LOG_OW-1:0]] <= cone_o;
        EMIT:   if (tt_ready && !seq_last) word_q <= '0;
        default: ;
      endcase
    end

  assign cone_i  = cone_q;
  assign tt_data = word_q;
endmodule

// File: tb/tb_bdd_cone_sampler.sv
// Scoreboard bench: two samplers (CONE_LAT=3 and 0) share stimulus; monitor pops expected words.
module tb_bdd_cone_sampler;
  localparam int IN_W = 1894, NVAR = 8, IDX_W = 11, OUT_W = 32, NVW = 4;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, tt_ready = 1'b1;
  logic [IN_W-1:0]       base_vec = '0;
  logic [NVAR*IDX_W-1:0] var_idx = '0;
  logic [NVW-1:0]        nvar = '0;
  int sel = 0;

  logic busy0, valid0, last0, done0, co0, busy1, valid1, last1, done1, co1;
  logic [IN_W-1:0]  ci0, ci1;
  logic [OUT_W-1:0] data0, data1;

  always #5 clk = ~clk;

  function automatic logic cone_fn(input int s, input logic [IN_W-1:0] v);
    case (s)
      0: return ^v[1718:1713];
      1: return v[5] & ~v[9];
      2: return v[63];
      3: return v[5];
      4: return v[7];
      default: return v[30];
    endcase
  endfunction

  assign co0 = cone_fn(sel, ci0);
  assign co1 = cone_fn(sel, ci1);

  bdd_cone_sampler #(.IN_W(IN_W), .NVAR(NVAR), .IDX_W(IDX_W), .OUT_W(OUT_W), .CONE_LAT(3)) u0 (
    .clk(clk), .rst(rst), .start(start), .base_vec(base_vec), .var_idx(var_idx), .nvar(nvar),
    .busy(busy0), .cone_i(ci0), .cone_o(co0), .tt_data(data0), .tt_valid(valid0),
    .tt_ready(tt_ready), .tt_last(last0), .done(done0));

  bdd_cone_sampler #(.IN_W(IN_W), .NVAR(NVAR), .IDX_W(IDX_W), .OUT_W(OUT_W), .CONE_LAT(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .base_vec(base_vec), .var_idx(var_idx), .nvar(nvar),
    .busy(busy1), .cone_i(ci1), .cone_o(co1), .tt_data(data1), .tt_valid(valid1),
    .tt_ready(tt_ready), .tt_last(last1), .done(done1));

  typedef struct packed {logic [31:0] d; logic l;} exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int tests = 0, fails = 0, dn0 = 0, dn1 = 0;
  logic pd0 = 1'b0, pd1 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    q0.push_back({d, l});
    q1.push_back({d, l});
  endtask

  always @(negedge clk) begin
    if (valid0 && tt_ready) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL u0 unexpected word: got %0h expected none", data0);
      end else begin
        e0 = q0.pop_front();
        check("u0 tt_data", 64'(data0), 64'(e0.d));
        check("u0 tt_last", 64'(last0), 64'(e0.l));
      end
    end
    if (valid1 && tt_ready) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL u1 unexpected word: got %0h expected none", data1);
      end else begin
        e1 = q1.pop_front();
        check("u1 tt_data", 64'(data1), 64'(e1.d));
        check("u1 tt_last", 64'(last1), 64'(e1.l));
      end
    end
    if (done0) begin
      check("u0 done one-cycle", 64'(pd0), 64'(0));
      check("u0 busy at done", 64'(busy0), 64'(1));
      dn0 <= dn0 + 1;
    end
    if (done1) begin
      check("u1 done one-cycle", 64'(pd1), 64'(0));
      dn1 <= dn1 + 1;
    end
    pd0 <= done0;
    pd1 <= done1;
  end

  function automatic logic [NVAR*IDX_W-1:0] idx8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [NVAR*IDX_W-1:0] r;
    int a[8];
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    r = '0;
    for (int k = 0; k < 8; k++) r[k*IDX_W +: IDX_W] = IDX_W'(a[k]);
    return r;
  endfunction

  // Inputs are scrambled right after start to show they are captured.
  task automatic kick(input int s, input logic [IN_W-1:0] b, input logic [NVAR*IDX_W-1:0] vi,
                      input logic [NVW-1:0] nv);
    sel = s; base_vec = b; var_idx = vi; nvar = nv;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    base_vec = '0; var_idx = '1; nvar = 4'd5;
  endtask

  task automatic finish_sweep(input string name, input int t0, input int t1);
    int n;
    n = 0;
    while (!(dn0 > t0 && dn1 > t1) && n < 8000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 8000) begin
      tests++; fails++;
      $display("FAIL %s timeout: got done0=%0d done1=%0d expected one more each", name, dn0, dn1);
    end
    @(negedge clk);
    check({name, " words left u0"}, 64'(q0.size()), 64'(0));
    check({name, " words left u1"}, 64'(q1.size()), 64'(0));
    check({name, " busy dropped"}, 64'(busy0 | busy1), 64'(0));
    check({name, " done count"}, 64'(dn0 - t0), 64'(1));
  endtask

  task automatic sweep(input string name, input int s, input logic [IN_W-1:0] b,
                       input logic [NVAR*IDX_W-1:0] vi, input logic [NVW-1:0] nv);
    int t0, t1;
    t0 = dn0; t1 = dn1;
    kick(s, b, vi, nv);
    finish_sweep(name, t0, t1);
  endtask

  logic [NVAR*IDX_W-1:0] par_idx;
  logic [IN_W-1:0] b63, snap;
  logic [2:0] cur, prev;
  logic [5:0] target;
  int seqv[7], cnt, n, t0, t1, bad;

  initial begin
    par_idx = idx8(1713, 1714, 1715, 1716, 1717, 1718, 0, 0);
    b63 = '0; b63[63] = 1'b1;
`ifdef SAMPLER_GRAY_EN
    seqv = '{1, 3, 2, 6, 7, 5, 4};
    target = 6'd25;
`else
    seqv = '{1, 2, 3, 4, 5, 6, 7};
    target = 6'd17;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 64'(busy0 | busy1), 64'(0));
    check("reset cone_i", 64'(|ci0 | |ci1), 64'(0));
    check("reset tt_data", 64'(data0 | data1), 64'(0));
    check("reset valid/last/done", 64'({valid0, last0, done0, valid1, last1, done1}), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    push(32'h96696996, 1'b0); push(32'h69969669, 1'b1);
    sweep("parity", 0, '0, par_idx, 4'd6);
    push(32'h00000002, 1'b1);
    sweep("and2", 1, '0, idx8(5, 9, 0, 0, 0, 0, 0, 0), 4'd2);
    push(32'h00000001, 1'b1);
    sweep("nvar0 one", 2, b63, '0, 4'd0);
    push(32'h00000000, 1'b1);
    sweep("nvar0 zero", 2, '0, '0, 4'd0);

    // Enumeration order observed on cone_i; previous sweep left these bits at 0.
    push(32'h000000F0, 1'b1);
    t0 = dn0; t1 = dn1;
    kick(5, '0, idx8(10, 20, 30, 0, 0, 0, 0, 0), 4'd3);
    prev = 3'd0; cnt = 0; n = 0;
    while (dn0 == t0 && n < 2000) begin
      @(negedge clk);
      n++;
      cur = {ci0[30], ci0[20], ci0[10]};
      if (cur != prev) begin
        if (cnt < 7) check("order step", 64'(cur), 64'(seqv[cnt]));
`ifdef SAMPLER_GRAY_EN
        check("gray hamming", 64'($countones(cur ^ prev)), 64'(1));
`endif
        cnt++;
        prev = cur;
      end
    end
    check("order count", 64'(cnt), 64'(7));
    finish_sweep("order", t0, t1);

    push(32'h0000000C, 1'b1);
    sweep("idx out of range", 3, '0, idx8(2000, 5, 0, 0, 0, 0, 0, 0), 4'd2);
    push(32'h0000000C, 1'b1);
    sweep("dup idx", 4, '0, idx8(7, 7, 0, 0, 0, 0, 0, 0), 4'd2);
    for (int w = 0; w < 8; w++) push(32'hAAAAAAAA, w == 7);
    sweep("nvar clamp", 3, '0, idx8(5, 2000, 2000, 2000, 2000, 2000, 2000, 2000), 4'd15);

    // Backpressure on the first word of the slow instance.
    @(posedge clk); #1 tt_ready = 1'b0;
    push(32'h96696996, 1'b0); push(32'h69969669, 1'b1);
    t0 = dn0; t1 = dn1;
    kick(0, '0, par_idx, 4'd6);
    n = 0;
    do begin @(negedge clk); n++; end while (!valid0 && n < 2000);
    check("bp valid seen", 64'(valid0), 64'(1));
    snap = ci0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp tt_data", 64'(data0), 64'(32'h96696996));
      check("bp tt_valid", 64'(valid0), 64'(1));
      check("bp cone_i held", 64'(ci0 !== snap), 64'(0));
    end
    @(posedge clk); #1 tt_ready = 1'b1;
    finish_sweep("backpressure", t0, t1);

    // Reset while the slow instance settles minterm 17.
    @(posedge clk); #1 tt_ready = 1'b0;
    kick(0, '0, par_idx, 4'd6);
    n = 0;
    do begin @(negedge clk); n++; end while (ci0[1718:1713] != target && n < 2000);
    check("rst reached minterm", 64'(ci0[1718:1713]), 64'(target));
    rst = 1'b1;
    #1;
    check("rst busy", 64'(busy0 | busy1), 64'(0));
    check("rst cone_i", 64'(|ci0 | |ci1), 64'(0));
    check("rst tt_data", 64'(data0 | data1), 64'(0));
    check("rst valid/last/done", 64'({valid0, last0, done0, valid1, last1, done1}), 64'(0));
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid0 || valid1 || busy0 || busy1) bad++;
    end
    check("rst quiet after", 64'(bad), 64'(0));
    @(posedge clk); #1 tt_ready = 1'b1;
    push(32'h96696996, 1'b0); push(32'h69969669, 1'b1);
    sweep("replay", 0, '0, par_idx, 4'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
